// File: rtl/exe_stage_pipe.sv
// exe_stage_pipe: registered ARM execute stage. Forwards Rn/Rm, builds Val2,
// runs the ALU and branch adder, and iterates MUL/MLA through a shift-add
// multiplier while holding off issue. Owns the EXE/MEM register and NZCV.
module exe_stage_pipe #(
  parameter int WIDTH      = 32,
  parameter int RADIX_BITS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             flush,
  input  logic [3:0]       exe_cmd,
  input  logic             s_bit,
  input  logic             imm,
  input  logic             wb_en,
  input  logic             mem_r_en,
  input  logic             mem_w_en,
  input  logic [11:0]      shift_operand,
  input  logic [23:0]      signed_imm_24,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] val_rn,
  input  logic [WIDTH-1:0] val_rm,
  input  logic [WIDTH-1:0] val_ra,
  input  logic [3:0]       wb_dest,
  input  logic [1:0]       sel_src1,
  input  logic [1:0]       sel_src2,
  input  logic [WIDTH-1:0] mem_fwd,
  input  logic [WIDTH-1:0] wb_fwd,
  output logic             out_valid,
  output logic [WIDTH-1:0] alu_result,
  output logic [WIDTH-1:0] br_addr,
  output logic [WIDTH-1:0] val_rm_out,
  output logic [3:0]       wb_dest_out,
  output logic             wb_en_out,
  output logic             mem_r_en_out,
  output logic             mem_w_en_out,
  output logic [3:0]       status
);
  localparam int N_ITER = WIDTH / RADIX_BITS;
  localparam int CNT_W  = $clog2(N_ITER);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ITER - 1);
  localparam int MSB = WIDTH - 1;

  typedef enum logic {IDLE, MUL_RUN} state_t;
  state_t state;

  logic [WIDTH-1:0] rn_fwd, rm_fwd, val2, shifted, alu_res, b_eff, pp, mul_next, br_calc;
  logic [WIDTH:0]   sum;
  logic [WIDTH+27:0] br_off;
  logic [3:0]       alu_flags;
  logic             alu_known, arith, cin_eff, accept, is_mul, is_mla, mem_op, mul_last;

  logic [WIDTH-1:0] mul_acc, mul_mcand, mul_mplier, pend_rm, pend_br;
  logic [CNT_W-1:0] mul_cnt;
  logic [3:0]       pend_dest;
  logic             pend_wb, pend_mem_r, pend_mem_w, pend_s;

  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel, input logic [WIDTH-1:0] reg_v,
                                               input logic [WIDTH-1:0] mem_v, input logic [WIDTH-1:0] wb_v);
    case (sel)
      2'b01:   return mem_v;
      2'b10:   return wb_v;
      default: return reg_v;
    endcase
  endfunction

  // Rotate right within WIDTH; amounts up to 31 fold back when WIDTH is narrow.
  function automatic logic [WIDTH-1:0] ror_w(input logic [WIDTH-1:0] x, input logic [4:0] amt);
    int a;
    logic [2*WIDTH-1:0] dbl;
    a = int'(amt);
    if (a >= WIDTH) a = a - WIDTH;
    dbl = {x, x} >> a;
    return dbl[WIDTH-1:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid & in_ready & ~flush;
  assign is_mla   = (exe_cmd == 4'b1011);
  assign is_mul   = (exe_cmd == 4'b1010) | is_mla;
  assign mem_op   = mem_r_en | mem_w_en;
  assign rn_fwd   = fwd_sel(sel_src1, val_rn, mem_fwd, wb_fwd);
  assign rm_fwd   = fwd_sel(sel_src2, val_rm, mem_fwd, wb_fwd);
  assign br_off   = {{(WIDTH+2){signed_imm_24[23]}}, signed_imm_24, 2'b00};
  assign br_calc  = pc + br_off[WIDTH-1:0];
  assign mul_last = (state == MUL_RUN) && (mul_cnt == LAST_CNT);
  assign mul_next = mul_acc + pp;

  // Val2: memory offset, rotated immediate, or shifted forwarded Rm
  always_comb begin
    shifted = rm_fwd;
    case (shift_operand[6:5])
      2'b00: shifted = rm_fwd << shift_operand[11:7];
      2'b01: shifted = rm_fwd >> shift_operand[11:7];
      2'b10: shifted = WIDTH'($signed(rm_fwd) >>> shift_operand[11:7]);
      default: shifted = ror_w(rm_fwd, shift_operand[11:7]);
    endcase
    if (mem_op)
      val2 = {{(WIDTH-12){1'b0}}, shift_operand};
    else if (imm)
      val2 = ror_w({{(WIDTH-8){1'b0}}, shift_operand[7:0]}, {shift_operand[11:8], 1'b0});
    else
      val2 = shifted;
  end

  // ALU result and candidate NZCV; subtraction runs as Rn + ~Val2 + carry
  always_comb begin
    alu_res   = '0;
    alu_known = 1'b0;
    arith     = 1'b0;
    b_eff     = val2;
    cin_eff   = 1'b0;
    case (exe_cmd)
      4'b0001: begin alu_res = val2;          alu_known = 1'b1; end
      4'b1001: begin alu_res = ~val2;         alu_known = 1'b1; end
      4'b0110: begin alu_res = rn_fwd & val2; alu_known = 1'b1; end
      4'b0111: begin alu_res = rn_fwd | val2; alu_known = 1'b1; end
      4'b1000: begin alu_res = rn_fwd ^ val2; alu_known = 1'b1; end
      4'b0010: begin arith = 1'b1; end
      4'b0011: begin arith = 1'b1; cin_eff = status[1]; end
      4'b0100: begin arith = 1'b1; b_eff = ~val2; cin_eff = 1'b1; end
      4'b0101: begin arith = 1'b1; b_eff = ~val2; cin_eff = status[1]; end
      default: ;
    endcase
    sum = {1'b0, rn_fwd} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    if (arith) begin
      alu_res   = sum[WIDTH-1:0];
      alu_known = 1'b1;
    end
    alu_flags = status;
    if (alu_known) begin
      alu_flags[3] = alu_res[MSB];
      alu_flags[2] = (alu_res == '0);
    end
    if (arith) begin
      alu_flags[1] = sum[WIDTH];
      alu_flags[0] = (rn_fwd[MSB] == b_eff[MSB]) && (alu_res[MSB] != rn_fwd[MSB]);
    end
  end

  // Partial product for the RADIX_BITS multiplier digits retired this cycle
  always_comb begin
    pp = '0;
    for (int j = 0; j < RADIX_BITS; j++)
      if (mul_mplier[j]) pp = pp + (mul_mcand << j);
  end

  // Issue FSM plus multiplier datapath and the pending MUL's controls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
      pend_rm    <= '0;
      pend_br    <= '0;
      pend_dest  <= '0;
      pend_wb    <= 1'b0;
      pend_mem_r <= 1'b0;
      pend_mem_w <= 1'b0;
      pend_s     <= 1'b0;
    end else if (flush) begin
      state   <= IDLE;
      mul_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            state      <= MUL_RUN;
            mul_acc    <= is_mla ? val_ra : '0;
            mul_mcand  <= rn_fwd;
            mul_mplier <= rm_fwd;
            mul_cnt    <= '0;
            pend_rm    <= rm_fwd;
            pend_br    <= br_calc;
            pend_dest  <= wb_dest;
            pend_wb    <= wb_en;
            pend_mem_r <= mem_r_en;
            pend_mem_w <= mem_w_en;
            pend_s     <= s_bit;
          end
        end
        default: begin
          mul_acc    <= mul_next;
          mul_mcand  <= mul_mcand << RADIX_BITS;
          mul_mplier <= mul_mplier >> RADIX_BITS;
          mul_cnt    <= mul_cnt + 1'b1;
          if (mul_last) state <= IDLE;
        end
      endcase
    end
  end

  // EXE/MEM register: loads on ALU accept or MUL completion, controls pulse once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      alu_result   <= '0;
      br_addr      <= '0;
      val_rm_out   <= '0;
      wb_dest_out  <= '0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
    end else begin
      out_valid    <= 1'b0;
      wb_en_out    <= 1'b0;
      mem_r_en_out <= 1'b0;
      mem_w_en_out <= 1'b0;
      if (!flush) begin
        if (accept && !is_mul) begin
          out_valid    <= 1'b1;
          alu_result   <= alu_res;
          br_addr      <= br_calc;
          val_rm_out   <= rm_fwd;
          wb_dest_out  <= wb_dest;
          wb_en_out    <= wb_en;
          mem_r_en_out <= mem_r_en;
          mem_w_en_out <= mem_w_en;
        end else if (mul_last) begin
          out_valid    <= 1'b1;
          alu_result   <= mul_next;
          br_addr      <= pend_br;
          val_rm_out   <= pend_rm;
          wb_dest_out  <= pend_dest;
          wb_en_out    <= pend_wb;
          mem_r_en_out <= pend_mem_r;
          mem_w_en_out <= pend_mem_w;
        end
      end
    end
  end

  // NZCV: written at commit for flag-setting non-memory ops; multiplies touch N,Z only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status <= 4'b0000;
    end else if (!flush) begin
      if (accept && !is_mul && s_bit && !mem_op && alu_known)
        status <= alu_flags;
      else if (mul_last && pend_s && !(pend_mem_r | pend_mem_w))
        status <= {mul_next[MSB], (mul_next == '0), status[1:0]};
    end
  end
endmodule
